// File: rtl/lotr_pkg.sv
// Shared LOTR ring types, widths and flop macros.
// Latency: n/a (types, one pure function and macros only).
// Backpressure: n/a.

`ifndef LOTR_FLOP_MACROS_SVH
`define LOTR_FLOP_MACROS_SVH

// Plain flop with asynchronous active-low reset.
`define LOTR_MSFF_RST(q, d, clk, rstN, rstVal) \
  always_ff @(posedge clk or negedge rstN) \
    if (!rstN) q <= (rstVal); \
    else q <= (d);

// Enabled flop with asynchronous active-low reset; holds when en is low.
`define LOTR_EN_MSFF_RST(q, d, en, clk, rstN, rstVal) \
  always_ff @(posedge clk or negedge rstN) \
    if (!rstN) q <= (rstVal); \
    else if (en) q <= (d);

`endif

package lotr_pkg;

  localparam int STARVE_CNT_W = 8;
  localparam int REQUESTOR_W  = 10;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int CORE_ID_W    = 8;

  typedef enum logic [1:0] {
    RD       = 2'd0,
    WR       = 2'd1,
    RD_RSP   = 2'd2,
    WR_BCAST = 2'd3
  } t_opcode;

  typedef enum logic [1:0] {
    NO_WINNER    = 2'd0,
    BYPASS_RING  = 2'd1,
    F2C_RESPONSE = 2'd2,
    C2F_REQUEST  = 2'd3
  } t_winner;

  typedef struct packed {
    logic [REQUESTOR_W-1:0] requestor;
    t_opcode                opcode;
    logic [ADDR_W-1:0]      address;
    logic [DATA_W-1:0]      data;
  } t_ringPkt;

  // Requests are sunk by the stop owning the target address; responses and
  // broadcasts are sunk by the stop that originated them (requestor id).
  function automatic logic isConsumedHere(input t_ringPkt pkt,
                                          input logic [CORE_ID_W-1:0] coreId);
    logic isReq;
    logic isRsp;
    isReq = (pkt.opcode == RD) || (pkt.opcode == WR);
    isRsp = (pkt.opcode == RD_RSP) || (pkt.opcode == WR_BCAST);
    return (isReq && (pkt.address[31:24] == coreId)) ||
           (isRsp && (pkt.requestor[9:2] == coreId));
  endfunction

endpackage

// File: rtl/ring_out_arb_rr_arb2.sv
// Two-way round-robin arbiter with a one-bit last-grant pointer.
// Latency: grant is combinational (0 cycles); pointer updates on the grant edge.
// Backpressure: enable low suppresses both grants and freezes the pointer.

module rr_arb2 (
  input  logic clk,
  input  logic rstN,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // High when requester 1 won the most recent grant; reset makes 0 win first tie.
  logic last1;
  logic anyGnt;

  // Lone requester wins outright; on a tie the side not granted last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        gnt0 = last1;
        gnt1 = !last1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign anyGnt = gnt0 | gnt1;

  // Pointer only moves when a grant is actually issued.
  `LOTR_EN_MSFF_RST(last1, gnt1, anyGnt, clk, rstN, 1'b1)

endmodule

// File: rtl/ring_out_arb.sv
// Ring stop output arbiter: ring bypass always wins, F2C/C2F share leftovers round-robin.
// Latency: grant combinational in Q501H, packet registered into Q502H (1 cycle).
// Backpressure: none on ring; locals hold valid until granted. Optional starvation
// counter/flag built only when LOTR_RING_ARB_STARVE_CNT_EN is defined.

module ring_out_arb
  import lotr_pkg::*;
#(
  parameter int unsigned STARVE_THR = 16
) (
  input  logic                    QClk,
  input  logic                    RstQnnnH,
  input  logic [CORE_ID_W-1:0]    CoreID,

  input  logic                    RingReqInValidQ501H,
  input  logic [REQUESTOR_W-1:0]  RingReqInRequestorQ501H,
  input  t_opcode                 RingReqInOpcodeQ501H,
  input  logic [ADDR_W-1:0]       RingReqInAddressQ501H,
  input  logic [DATA_W-1:0]       RingReqInDataQ501H,

  input  logic                    F2C_RspValidQ501H,
  input  logic [REQUESTOR_W-1:0]  F2C_RspRequestorQ501H,
  input  t_opcode                 F2C_RspOpcodeQ501H,
  input  logic [ADDR_W-1:0]       F2C_RspAddressQ501H,
  input  logic [DATA_W-1:0]       F2C_RspDataQ501H,

  input  logic                    C2F_ReqValidQ501H,
  input  logic [REQUESTOR_W-1:0]  C2F_ReqRequestorQ501H,
  input  t_opcode                 C2F_ReqOpcodeQ501H,
  input  logic [ADDR_W-1:0]       C2F_ReqAddressQ501H,
  input  logic [DATA_W-1:0]       C2F_ReqDataQ501H,

  output t_winner                 SelRingRspOutQ501H,

  output logic                    RingRspOutValidQ502H,
  output logic [REQUESTOR_W-1:0]  RingRspOutRequestorQ502H,
  output t_opcode                 RingRspOutOpcodeQ502H,
  output logic [ADDR_W-1:0]       RingRspOutAddressQ502H,
  output logic [DATA_W-1:0]       RingRspOutDataQ502H,

  output logic [STARVE_CNT_W-1:0] StarveCntQ502H,
  output logic                    StarveFlagQ502H
);

  // Threshold must be representable by the 8-bit counter and non-zero.
  if (STARVE_THR < 1 || STARVE_THR > 255) begin : gBadStarveThr
    $error("ring_out_arb: STARVE_THR must be in 1..255");
  end

  t_ringPkt ringPktQ501H;
  t_ringPkt f2cPktQ501H;
  t_ringPkt c2fPktQ501H;
  t_ringPkt outPktNxtQ501H;
  t_ringPkt outPktQ502H;

  logic    ringFwdQ501H;
  logic    gntF2cQ501H;
  logic    gntC2fQ501H;
  logic    anyGrantQ501H;
  t_winner selQ501H;
  logic    outValidQ502H;

  assign ringPktQ501H = '{requestor: RingReqInRequestorQ501H,
                          opcode:    RingReqInOpcodeQ501H,
                          address:   RingReqInAddressQ501H,
                          data:      RingReqInDataQ501H};

  assign f2cPktQ501H  = '{requestor: F2C_RspRequestorQ501H,
                          opcode:    F2C_RspOpcodeQ501H,
                          address:   F2C_RspAddressQ501H,
                          data:      F2C_RspDataQ501H};

  assign c2fPktQ501H  = '{requestor: C2F_ReqRequestorQ501H,
                          opcode:    C2F_ReqOpcodeQ501H,
                          address:   C2F_ReqAddressQ501H,
                          data:      C2F_ReqDataQ501H};

  // A ring packet sunk at this stop frees the output slot for local traffic.
  assign ringFwdQ501H = RingReqInValidQ501H & !isConsumedHere(ringPktQ501H, CoreID);

  // Local sources only compete when the ring does not need the slot.
  rr_arb2 uLocalArb (
    .clk    (QClk),
    .rstN   (RstQnnnH),
    .enable (!ringFwdQ501H),
    .req0   (F2C_RspValidQ501H),
    .req1   (C2F_ReqValidQ501H),
    .gnt0   (gntF2cQ501H),
    .gnt1   (gntC2fQ501H)
  );

  // Winner select and output-packet mux; ring bypass has absolute priority.
  always_comb begin
    selQ501H       = NO_WINNER;
    outPktNxtQ501H = ringPktQ501H;
    if (ringFwdQ501H) begin
      selQ501H       = BYPASS_RING;
      outPktNxtQ501H = ringPktQ501H;
    end else if (gntF2cQ501H) begin
      selQ501H       = F2C_RESPONSE;
      outPktNxtQ501H = f2cPktQ501H;
    end else if (gntC2fQ501H) begin
      selQ501H       = C2F_REQUEST;
      outPktNxtQ501H = c2fPktQ501H;
    end
  end

  assign SelRingRspOutQ501H = selQ501H;
  assign anyGrantQ501H      = (selQ501H != NO_WINNER);

  // Output valid follows the grant one cycle later.
  `LOTR_MSFF_RST(outValidQ502H, anyGrantQ501H, QClk, RstQnnnH, 1'b0)

  // Output fields load only on a grant so they hold across idle cycles.
  `LOTR_EN_MSFF_RST(outPktQ502H, outPktNxtQ501H, anyGrantQ501H, QClk, RstQnnnH, '0)

  assign RingRspOutValidQ502H     = outValidQ502H;
  assign RingRspOutRequestorQ502H = outPktQ502H.requestor;
  assign RingRspOutOpcodeQ502H    = outPktQ502H.opcode;
  assign RingRspOutAddressQ502H   = outPktQ502H.address;
  assign RingRspOutDataQ502H      = outPktQ502H.data;

`ifdef LOTR_RING_ARB_STARVE_CNT_EN

  logic [STARVE_CNT_W-1:0] starveCntQ502H;
  logic [STARVE_CNT_W-1:0] starveCntNxtQ501H;
  logic                    starveFlagQ502H;
  logic                    starveFlagNxtQ501H;
  logic                    localDeniedQ501H;
  logic                    localGrantQ501H;

  assign localDeniedQ501H = ringFwdQ501H & (F2C_RspValidQ501H | C2F_ReqValidQ501H);
  assign localGrantQ501H  = gntF2cQ501H | gntC2fQ501H;

  // Count cycles locals lose to the ring; saturate at all-ones, clear on local grant.
  always_comb begin
    starveCntNxtQ501H = starveCntQ502H;
    if (localGrantQ501H) begin
      starveCntNxtQ501H = '0;
    end else if (localDeniedQ501H && (starveCntQ502H != '1)) begin
      starveCntNxtQ501H = starveCntQ502H + STARVE_CNT_W'(1);
    end
  end

  // Flag compares the next count so it rises in the same cycle the count reaches threshold.
  assign starveFlagNxtQ501H = starveFlagQ502H | (32'(starveCntNxtQ501H) >= STARVE_THR);

  // Starvation counter state.
  `LOTR_MSFF_RST(starveCntQ502H, starveCntNxtQ501H, QClk, RstQnnnH, '0)

  // Sticky starvation flag, cleared only by reset.
  `LOTR_MSFF_RST(starveFlagQ502H, starveFlagNxtQ501H, QClk, RstQnnnH, 1'b0)

  assign StarveCntQ502H  = starveCntQ502H;
  assign StarveFlagQ502H = starveFlagQ502H;

`else

  assign StarveCntQ502H  = '0;
  assign StarveFlagQ502H = 1'b0;

`endif

endmodule

// File: tb/tb_ring_out_arb.sv
// Directed, table-driven bench for ring_out_arb with CoreID=0x02.
// Latency checked: grant at negedge of the drive cycle, Q502H one edge later.
// Multi-cycle corners (async reset, starvation, saturation) are hand sequences.

module tb_ring_out_arb;
  import lotr_pkg::*;

`ifdef LOTR_RING_ARB_STARVE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                    QClk = 1'b0;
  logic                    RstQnnnH;
  logic [7:0]              CoreID;
  logic                    ringVld;
  logic [9:0]              ringReq;
  t_opcode                 ringOp;
  logic [31:0]             ringAddr;
  logic [31:0]             ringData;
  logic                    f2cVld;
  logic [9:0]              f2cReq;
  t_opcode                 f2cOp;
  logic [31:0]             f2cAddr;
  logic [31:0]             f2cData;
  logic                    c2fVld;
  logic [9:0]              c2fReq;
  t_opcode                 c2fOp;
  logic [31:0]             c2fAddr;
  logic [31:0]             c2fData;
  t_winner                 sel;
  logic                    outVld;
  logic [9:0]              outReq;
  t_opcode                 outOp;
  logic [31:0]             outAddr;
  logic [31:0]             outData;
  logic [7:0]              starveCnt;
  logic                    starveFlag;

  always #5 QClk = ~QClk;

  ring_out_arb #(.STARVE_THR(16)) dut (
    .QClk                     (QClk),
    .RstQnnnH                 (RstQnnnH),
    .CoreID                   (CoreID),
    .RingReqInValidQ501H      (ringVld),
    .RingReqInRequestorQ501H  (ringReq),
    .RingReqInOpcodeQ501H     (ringOp),
    .RingReqInAddressQ501H    (ringAddr),
    .RingReqInDataQ501H       (ringData),
    .F2C_RspValidQ501H        (f2cVld),
    .F2C_RspRequestorQ501H    (f2cReq),
    .F2C_RspOpcodeQ501H       (f2cOp),
    .F2C_RspAddressQ501H      (f2cAddr),
    .F2C_RspDataQ501H         (f2cData),
    .C2F_ReqValidQ501H        (c2fVld),
    .C2F_ReqRequestorQ501H    (c2fReq),
    .C2F_ReqOpcodeQ501H       (c2fOp),
    .C2F_ReqAddressQ501H      (c2fAddr),
    .C2F_ReqDataQ501H         (c2fData),
    .SelRingRspOutQ501H       (sel),
    .RingRspOutValidQ502H     (outVld),
    .RingRspOutRequestorQ502H (outReq),
    .RingRspOutOpcodeQ502H    (outOp),
    .RingRspOutAddressQ502H   (outAddr),
    .RingRspOutDataQ502H      (outData),
    .StarveCntQ502H           (starveCnt),
    .StarveFlagQ502H          (starveFlag)
  );

  int nVec = 0;
  int nMis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       nm;
    logic        rv;
    logic [9:0]  rReq;
    t_opcode     rOp;
    logic [31:0] rAddr;
    logic        fv;
    logic        cv;
    t_winner     expSel;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic rv, input logic [9:0] rq,
                              input t_opcode op, input logic [31:0] a,
                              input logic fv, input logic cv, input t_winner s);
    vec_t v;
    v.nm = nm; v.rv = rv; v.rReq = rq; v.rOp = op; v.rAddr = a;
    v.fv = fv; v.cv = cv; v.expSel = s;
    return v;
  endfunction

  // Local packets carry a per-vector tag so each winner's fields are distinct.
  task automatic drive(input logic rv, input logic [9:0] rq, input t_opcode op,
                       input logic [31:0] a, input logic fv, input logic cv, input int tag);
    ringVld  = rv;
    ringReq  = rq;
    ringOp   = op;
    ringAddr = a;
    ringData = a ^ 32'h5A5A_5A5A;
    f2cVld   = fv;
    f2cReq   = 10'h3F0;
    f2cOp    = RD_RSP;
    f2cAddr  = 32'hF2C0_0000 + 32'(tag);
    f2cData  = 32'h1111_0000 + 32'(tag);
    c2fVld   = cv;
    c2fReq   = 10'h00C;
    c2fOp    = WR;
    c2fAddr  = 32'hC2F0_0000 + 32'(tag);
    c2fData  = 32'h2222_0000 + 32'(tag);
  endtask

  vec_t        vecs[$];
  logic        eVld;
  logic [9:0]  eReq;
  t_opcode     eOp;
  logic [31:0] eAddr;
  logic [31:0] eData;

  initial begin
    CoreID   = 8'h02;
    RstQnnnH = 1'b0;
    drive(1'b0, 10'h0, RD, 32'h0, 1'b0, 1'b0, 0);

    vecs.push_back(mk("idle",          0, 10'h000, RD,       32'h0000_0000, 0, 0, NO_WINNER));
    vecs.push_back(mk("ringRdFwdF2c",  1, 10'h004, RD,       32'h0300_0010, 1, 0, BYPASS_RING));
    vecs.push_back(mk("f2cHeldThenWin",0, 10'h000, RD,       32'h0000_0000, 1, 0, F2C_RESPONSE));
    vecs.push_back(mk("bcastOwnSunk",  1, 10'h008, WR_BCAST, 32'h0900_0000, 0, 0, NO_WINNER));
    vecs.push_back(mk("bcastOtherFwd", 1, 10'h014, WR_BCAST, 32'h0200_0000, 0, 0, BYPASS_RING));
    vecs.push_back(mk("c2fAlone",      0, 10'h000, RD,       32'h0000_0000, 0, 1, C2F_REQUEST));
    vecs.push_back(mk("tie1",          0, 10'h000, RD,       32'h0000_0000, 1, 1, F2C_RESPONSE));
    vecs.push_back(mk("tie2",          0, 10'h000, RD,       32'h0000_0000, 1, 1, C2F_REQUEST));
    vecs.push_back(mk("tie3",          0, 10'h000, RD,       32'h0000_0000, 1, 1, F2C_RESPONSE));
    vecs.push_back(mk("tie4",          0, 10'h000, RD,       32'h0000_0000, 1, 1, C2F_REQUEST));
    vecs.push_back(mk("rdSunkC2f",     1, 10'h3FC, RD,       32'h0200_0040, 0, 1, C2F_REQUEST));
    vecs.push_back(mk("rdRspSunkTie",  1, 10'h00B, RD_RSP,   32'hAB00_0000, 1, 1, F2C_RESPONSE));
    vecs.push_back(mk("wrSunkTie",     1, 10'h000, WR,       32'h02FF_FFFC, 1, 1, C2F_REQUEST));
    vecs.push_back(mk("wrFwdTie",      1, 10'h000, WR,       32'h0100_0000, 1, 1, BYPASS_RING));
    vecs.push_back(mk("tiePtrKept",    0, 10'h000, RD,       32'h0000_0000, 1, 1, F2C_RESPONSE));
    vecs.push_back(mk("rdReqIdIgnored",1, 10'h008, RD,       32'h0500_0000, 0, 0, BYPASS_RING));
    vecs.push_back(mk("rdRspFwdC2f",   1, 10'h01C, RD_RSP,   32'h0200_0000, 0, 1, BYPASS_RING));
    vecs.push_back(mk("c2fAfterRing",  0, 10'h000, RD,       32'h0000_0000, 0, 1, C2F_REQUEST));
    vecs.push_back(mk("idleEnd",       0, 10'h000, RD,       32'h0000_0000, 0, 0, NO_WINNER));

    // Reset state.
    repeat (2) @(posedge QClk);
    @(negedge QClk);
    RstQnnnH = 1'b1;
    #1;
    chk("rst/vld",  64'(outVld), 64'd0);
    chk("rst/addr", 64'(outAddr), 64'd0);
    chk("rst/data", 64'(outData), 64'd0);
    chk("rst/reqop", 64'({outReq, outOp}), 64'd0);
    chk("rst/cnt",  64'(starveCnt), 64'd0);
    chk("rst/flag", 64'(starveFlag), 64'd0);
    chk("rst/sel",  64'(sel), 64'(NO_WINNER));

    eVld = 1'b0; eReq = '0; eOp = RD; eAddr = '0; eData = '0;
    @(posedge QClk); #1;

    // Table: grant at negedge, registered packet after the next edge.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rv, vecs[i].rReq, vecs[i].rOp, vecs[i].rAddr, vecs[i].fv, vecs[i].cv, i);
      @(negedge QClk);
      chk($sformatf("%s/sel", vecs[i].nm), 64'(sel), 64'(vecs[i].expSel));
      eVld = (vecs[i].expSel != NO_WINNER);
      case (vecs[i].expSel)
        BYPASS_RING:  begin eReq = ringReq; eOp = ringOp; eAddr = vecs[i].rAddr;
                            eData = vecs[i].rAddr ^ 32'h5A5A_5A5A; end
        F2C_RESPONSE: begin eReq = 10'h3F0; eOp = RD_RSP; eAddr = 32'hF2C0_0000 + 32'(i);
                            eData = 32'h1111_0000 + 32'(i); end
        C2F_REQUEST:  begin eReq = 10'h00C; eOp = WR; eAddr = 32'hC2F0_0000 + 32'(i);
                            eData = 32'h2222_0000 + 32'(i); end
        default: ;
      endcase
      @(posedge QClk); #1;
      chk($sformatf("%s/vld", vecs[i].nm),   64'(outVld), 64'(eVld));
      chk($sformatf("%s/addr", vecs[i].nm),  64'(outAddr), 64'(eAddr));
      chk($sformatf("%s/data", vecs[i].nm),  64'(outData), 64'(eData));
      chk($sformatf("%s/reqop", vecs[i].nm), 64'({outReq, outOp}), 64'({eReq, eOp}));
    end

    // Asynchronous reset mid-stream, then first tie after release goes to F2C.
    drive(1'b1, 10'h004, RD, 32'h0300_0010, 1'b0, 1'b0, 0);
    @(posedge QClk); #1;
    chk("arst/vldBefore", 64'(outVld), 64'd1);
    #2;
    RstQnnnH = 1'b0;
    #1;
    chk("arst/vldNow",  64'(outVld), 64'd0);
    chk("arst/addrNow", 64'(outAddr), 64'd0);
    chk("arst/dataNow", 64'(outData), 64'd0);
    drive(1'b0, 10'h000, RD, 32'h0, 1'b1, 1'b1, 77);
    @(negedge QClk);
    RstQnnnH = 1'b1;
    #1;
    chk("arst/tieSel", 64'(sel), 64'(F2C_RESPONSE));
    @(posedge QClk); #1;
    chk("arst/tieVld",  64'(outVld), 64'd1);
    chk("arst/tieAddr", 64'(outAddr), 64'(32'hF2C0_0000 + 32'd77));

    // Starvation: C2F waits under 20 cycles of forwarded ring traffic.
    drive(1'b1, 10'h004, WR, 32'h0700_0000, 1'b0, 1'b1, 5);
    for (int k = 1; k <= 20; k++) begin
      @(negedge QClk);
      chk($sformatf("starve%0d/sel", k), 64'(sel), 64'(BYPASS_RING));
      @(posedge QClk); #1;
      chk($sformatf("starve%0d/cnt", k),  64'(starveCnt), CNT_EN ? 64'(k) : 64'd0);
      chk($sformatf("starve%0d/flag", k), 64'(starveFlag), 64'(CNT_EN && (k >= 16)));
    end
    drive(1'b0, 10'h000, RD, 32'h0, 1'b0, 1'b1, 5);
    @(negedge QClk);
    chk("starveGrant/sel", 64'(sel), 64'(C2F_REQUEST));
    @(posedge QClk); #1;
    chk("starveGrant/cnt",  64'(starveCnt), 64'd0);
    chk("starveGrant/flag", 64'(starveFlag), 64'(CNT_EN));

    // Saturation: 260 denied cycles leave the counter pinned at 255.
    drive(1'b1, 10'h004, WR, 32'h0700_0000, 1'b1, 1'b0, 6);
    repeat (260) @(posedge QClk);
    #1;
    chk("sat/cnt",  64'(starveCnt), CNT_EN ? 64'd255 : 64'd0);
    chk("sat/flag", 64'(starveFlag), 64'(CNT_EN));
    drive(1'b0, 10'h000, RD, 32'h0, 1'b1, 1'b0, 6);
    @(posedge QClk); #1;
    chk("satGrant/cnt", 64'(starveCnt), 64'd0);
    chk("satGrant/vld", 64'(outVld), 64'd1);
    chk("satGrant/addr", 64'(outAddr), 64'(32'hF2C0_0006));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/ring_out_arb.md
RING_OUT_ARB -- requirements
Module: ring_out_arb

Interface
REQ-001 SHALL have parameter STARVE_THR, default 16, starvation-flag threshold in cycles (1..255).
REQ-002 SHALL have port QClk  input  1  the single clock.
REQ-003 SHALL have port RstQnnnH  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port CoreID  input  8  local core id.
REQ-005 SHALL have ports RingReqInValidQ501H/RequestorQ501H/OpcodeQ501H/AddressQ501H/DataQ501H  input  1/10/t_opcode/32/32  ring packet arriving at this stop.
REQ-006 SHALL have ports F2C_RspValidQ501H/RequestorQ501H/OpcodeQ501H/AddressQ501H/DataQ501H  input  1/10/t_opcode/32/32  read response from the fabric-to-core buffer.
REQ-007 SHALL have ports C2F_ReqValidQ501H/RequestorQ501H/OpcodeQ501H/AddressQ501H/DataQ501H  input  1/10/t_opcode/32/32  request from the core-to-fabric buffer.
REQ-008 SHALL have port SelRingRspOutQ501H  output  t_winner  combinational grant, fed back to both buffers.
REQ-009 SHALL have ports RingRspOutValidQ502H/RequestorQ502H/OpcodeQ502H/AddressQ502H/DataQ502H  output  1/10/t_opcode/32/32  registered packet to next ring stop.
REQ-010 SHALL have ports StarveCntQ502H  output  8  and  StarveFlagQ502H  output  1  starvation status.

Function
REQ-011 SHALL compute RingFwd = RingReqInValid AND NOT consumed-here; consumed-here = (Opcode in {RD,WR} and Address[31:24]==CoreID) or (Opcode in {RD_RSP,WR_BCAST} and Requestor[9:2]==CoreID).
REQ-012 SHALL grant BYPASS_RING whenever RingFwd=1; ring traffic is never stalled or dropped.
REQ-013 SHALL, with RingFwd=0 and one local source valid, grant it (F2C_RESPONSE or C2F_REQUEST).
REQ-014 SHALL, with RingFwd=0 and both local sources valid, grant the one not granted last (1-bit LastLocal pointer).
REQ-015 SHALL update LastLocal only on a local grant; reset value = C2F, so F2C wins the first tie.
REQ-016 SHALL drive SelRingRspOutQ501H=NO_WINNER when no source is valid.
REQ-017 SHALL, on any grant, load the winner's fields into the Q502H registers and set RingRspOutValidQ502H=1 next cycle (latency 1).
REQ-018 SHALL clear RingRspOutValidQ502H on NO_WINNER; data fields hold their last value.
REQ-019 Local sources SHALL hold valid and fields stable until granted; the block stores no local packet.
REQ-020 SHALL be unaffected by a ring packet and local valids rising in the same cycle: ring wins, locals wait, pointer unchanged.

Reset
REQ-021 SHALL, on RstQnnnH=0 (asynchronous, any cycle incl. mid-packet), force RingRspOutValidQ502H=0, all Q502H fields=0, LastLocal=C2F, StarveCntQ502H=0, StarveFlagQ502H=0.
REQ-022 SHALL resume arbitration on the first QClk edge after release; an in-flight Q502H packet is lost.

Configuration
REQ-023 Macro LOTR_RING_ARB_STARVE_CNT_EN defined: counter increments each cycle any local valid is denied by BYPASS_RING, saturates at 255, clears on any local grant.
REQ-024 With the macro defined: StarveFlagQ502H sets when counter >= STARVE_THR, sticky until reset.
REQ-025 Macro undefined: no counter logic; StarveCntQ502H and StarveFlagQ502H tied to 0.

Structure
REQ-026 t_winner {NO_WINNER, BYPASS_RING, F2C_RESPONSE, C2F_REQUEST}, t_opcode and STARVE_CNT_W=8 SHALL live in lotr_pkg.
REQ-027 Arbitration SHALL be combinational in the top module; sub-module rr_arb2 (2-way round-robin with pointer flop) is natural.
REQ-028 Flops SHALL use the standard LOTR flop macros.

Verification
REQ-029 CoreID=0x02, ring RD to Address 0x0300_0010 with F2C valid -> grant BYPASS_RING, next cycle Valid=1, Address=0x0300_0010; F2C held.
REQ-030 F2C and C2F valid 4 cycles, no ring -> grants F2C,C2F,F2C,C2F; Q502H fields match each winner.
REQ-031 Ring WR_BCAST with Requestor[9:2]=0x02 -> NO_WINNER, next Valid=0; with Requestor[9:2]=0x05 -> forwarded.
REQ-032 Macro on, STARVE_THR=16, C2F valid under 20 cycles of forwarded ring traffic -> cnt=16 and flag=1 at cycle 16, cnt=20 at cycle 20; on grant cnt=0, flag stays 1.
REQ-033 RstQnnnH=0 mid-stream with Valid=1 -> Valid=0 immediately (no clock edge); after release tie goes to F2C.
